// File: rtl/ps2_keycode_source_pkg.sv
// Shared types and constants for the PS/2 keycode source: receiver states,
// Set-2 scan codes, HID usages and the scan-code to usage lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    // Arrow keys only exist behind the E0 prefix; everything else maps to KEY_NONE.
    function automatic logic [7:0] hid_lookup(input logic [7:0] code, input logic ext);
        logic [7:0] usage;
        usage = KEY_NONE;
        case ({ext, code})
            {1'b0, SC_A}:     usage = KEY_A;
            {1'b0, SC_D}:     usage = KEY_D;
            {1'b0, SC_W}:     usage = KEY_W;
            {1'b0, SC_S}:     usage = KEY_S;
            {1'b0, SC_SPACE}: usage = KEY_SPACE;
            {1'b1, SC_UP}:    usage = KEY_UP;
            {1'b1, SC_DOWN}:  usage = KEY_DOWN;
            {1'b1, SC_LEFT}:  usage = KEY_LEFT;
            {1'b1, SC_RIGHT}: usage = KEY_RIGHT;
            default:          usage = KEY_NONE;
        endcase
        return usage;
    endfunction

endpackage

// File: rtl/ps2_keycode_source_if.sv
// Pin and result bundle of the PS/2 keycode source; master is the decoder,
// slave is the board/game side that drives the pins and consumes the keycode.
interface ps2_keycode_source_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_event;
    logic [7:0] scan_byte;
    logic       scan_valid;
    logic       frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output keycode, key_event, scan_byte, scan_valid, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  keycode, key_event, scan_byte, scan_valid, frame_err
    );
endinterface

// File: rtl/ps2_keycode_source_rx.sv
// PS/2 frame receiver: pin synchroniser, falling-edge detect, frame FSM and timeout.
// PS2_PARITY_CHECK_EN enables rejection of frames with bad odd parity.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_byte,
    output logic       scan_valid,
    output logic       frame_err
);
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    genvar gi;
    // Synchronisers reset to the idle-high line level so reset never fakes an edge.
    for (gi = 0; gi < STAGES; gi++) begin : g_sync
        logic clk_q;
        logic data_q;
        always_ff @(posedge Clk) begin
            if (Reset) begin
                clk_q  <= 1'b1;
                data_q <= 1'b1;
            end else if (gi == 0) begin
                clk_q  <= ps2_clk;
                data_q <= ps2_data;
            end else begin
                clk_q  <= g_sync[(gi == 0) ? 0 : gi-1].clk_q;
                data_q <= g_sync[(gi == 0) ? 0 : gi-1].data_q;
            end
        end
    end

    logic clk_s, data_s, clk_prev_reg, fall;
    assign clk_s  = g_sync[STAGES-1].clk_q;
    assign data_s = g_sync[STAGES-1].data_q;
    assign fall   = clk_prev_reg & ~clk_s;

    rx_state_t        state_reg, state_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             parity_reg, parity_next;
    logic [CNT_W-1:0] timeout_cnt_reg, timeout_cnt_next;
    logic [7:0]       scan_byte_reg, scan_byte_next;
    logic             scan_valid_reg, scan_valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             parity_good, parity_ok;

    assign parity_good = ^{shift_reg, parity_reg};
`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = parity_good;
`else
    // Parity is still captured and computed but never rejects a frame.
    assign parity_ok = 1'b1 | parity_good;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_prev_reg    <= 1'b1;
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            timeout_cnt_reg <= '0;
            scan_byte_reg   <= '0;
            scan_valid_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            clk_prev_reg    <= clk_s;
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            parity_reg      <= parity_next;
            timeout_cnt_reg <= timeout_cnt_next;
            scan_byte_reg   <= scan_byte_next;
            scan_valid_reg  <= scan_valid_next;
            frame_err_reg   <= frame_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        parity_next      = parity_reg;
        timeout_cnt_next = '0;
        scan_byte_next   = scan_byte_reg;
        scan_valid_next  = 1'b0;
        frame_err_next   = 1'b0;

        if (state_reg != ST_IDLE && !fall)
            timeout_cnt_next = timeout_cnt_reg + CNT_W'(1);

        case (state_reg)
            ST_IDLE: begin
                if (fall && !data_s) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_next   = {data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_next = data_s;
                    state_next  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_next = ST_IDLE;
                    if (data_s && parity_ok) begin
                        scan_byte_next  = shift_reg;
                        scan_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A falling edge in the same cycle always beats the timeout.
        if (state_reg != ST_IDLE && !fall && timeout_cnt_reg == CNT_LAST) begin
            state_next       = ST_IDLE;
            frame_err_next   = 1'b1;
            timeout_cnt_next = '0;
        end
    end

    assign scan_byte  = scan_byte_reg;
    assign scan_valid = scan_valid_reg;
    assign frame_err  = frame_err_reg;
endmodule

// File: rtl/ps2_keycode_source.sv
// PS/2 keyboard to HID keycode source: frame receiver plus E0/F0 prefix decoder
// holding the last pressed key. Optional parity rejection: PS2_PARITY_CHECK_EN.
module ps2_keycode_source
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    ps2_keycode_source_if.master bus
);
    logic [7:0] scan_byte;
    logic       scan_valid;
    logic       frame_err;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .Clk        (Clk),
        .Reset      (Reset),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .scan_byte  (scan_byte),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    logic       ext_reg, ext_next;
    logic       brk_reg, brk_next;
    logic [7:0] keycode_reg, keycode_next;
    logic       key_event_reg, key_event_next;
    logic [7:0] usage;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext_reg       <= 1'b0;
            brk_reg       <= 1'b0;
            keycode_reg   <= KEY_NONE;
            key_event_reg <= 1'b0;
        end else begin
            ext_reg       <= ext_next;
            brk_reg       <= brk_next;
            keycode_reg   <= keycode_next;
            key_event_reg <= key_event_next;
        end
    end

    always_comb begin
        ext_next     = ext_reg;
        brk_next     = brk_reg;
        keycode_next = keycode_reg;
        usage        = hid_lookup(scan_byte, ext_reg);

        if (scan_valid) begin
            if (scan_byte == SC_EXT) begin
                ext_next = 1'b1;
            end else if (scan_byte == SC_BRK) begin
                brk_next = 1'b1;
            end else begin
                ext_next = 1'b0;
                brk_next = 1'b0;
                // A break only releases the key it names; a newer press survives.
                if (usage != KEY_NONE) begin
                    if (brk_reg) begin
                        if (keycode_reg == usage)
                            keycode_next = KEY_NONE;
                    end else begin
                        keycode_next = usage;
                    end
                end
            end
        end

        // Typematic repeats leave keycode unchanged, so they raise no event.
        key_event_next = (keycode_next != keycode_reg);
    end

    assign bus.keycode    = keycode_reg;
    assign bus.key_event  = key_event_reg;
    assign bus.scan_byte  = scan_byte;
    assign bus.scan_valid = scan_valid;
    assign bus.frame_err  = frame_err;
endmodule

// File: tb/tb_ps2_keycode_source.sv
// Self-checking bench for ps2_keycode_source: directed frame table, randomized
// frames against a scan-code level reference model, and timeout/reset sequences.
module tb_ps2_keycode_source;
    localparam int TO = 100;
    localparam int HB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_keycode_source_if bus();

    ps2_keycode_source #(
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int ev_cnt   = 0;
    int err_cnt  = 0;
    int sv_cnt   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.key_event)  ev_cnt  <= ev_cnt + 1;
            if (bus.frame_err)  err_cnt <= err_cnt + 1;
            if (bus.scan_valid) sv_cnt  <= sv_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic pin_bit(input logic d);
        bus.ps2_data = d;
        repeat (HB) @(posedge clk);
        #1 bus.ps2_clk = 1'b0;
        repeat (HB) @(posedge clk);
        #1 bus.ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] code, input bit flip_par, input bit stop);
        logic par;
        par = (~^code) ^ flip_par;
        return {stop, par, code, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) pin_bit(f[i]);
    endtask

    task automatic idle_wait(input int n);
        bus.ps2_data = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit flip_par, input bit stop);
        send_bits(make_frame(code, flip_par, stop), 11);
        idle_wait(12);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Reference model: keyed by ext*256+code, filled straight from the key map.
    logic [7:0] ref_map [int];
    logic       m_ext, m_brk;
    logic [7:0] m_key;

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            k = (m_ext ? 256 : 0) + int'(b);
            if (ref_map.exists(k)) begin
                if (!m_brk) m_key = ref_map[k];
                else if (m_key == ref_map[k]) m_key = 8'h00;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] code;
        bit         flip;
        bit         stop;
        logic [7:0] exp_key;
        int         exp_ev;
        int         exp_err;
        logic [7:0] exp_sb;
    } vec_t;

    vec_t tbl[$];

    logic [7:0] pool [13] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h75, 8'h72,
                              8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h12, 8'h5A};

    initial begin
        int ev0, err0, sv0, prev_key;
        logic [7:0] b, sb_exp;
        bit stop;

        ref_map[int'(8'h1C)] = 8'h04;  ref_map[int'(8'h23)] = 8'h07;
        ref_map[int'(8'h1D)] = 8'h1A;  ref_map[int'(8'h1B)] = 8'h16;
        ref_map[int'(8'h29)] = 8'h2C;
        ref_map[256 + int'(8'h75)] = 8'h52;  ref_map[256 + int'(8'h72)] = 8'h51;
        ref_map[256 + int'(8'h6B)] = 8'h50;  ref_map[256 + int'(8'h74)] = 8'h4F;

        tbl.push_back('{8'h1C, 0, 1, 8'h04, 1, 0, 8'h1C});
        tbl.push_back('{8'h23, 0, 1, 8'h07, 1, 0, 8'h23});
        tbl.push_back('{8'hF0, 0, 1, 8'h07, 0, 0, 8'hF0});
        tbl.push_back('{8'h1C, 0, 1, 8'h07, 0, 0, 8'h1C});
        tbl.push_back('{8'hF0, 0, 1, 8'h07, 0, 0, 8'hF0});
        tbl.push_back('{8'h23, 0, 1, 8'h00, 1, 0, 8'h23});
        tbl.push_back('{8'hE0, 0, 1, 8'h00, 0, 0, 8'hE0});
        tbl.push_back('{8'h75, 0, 1, 8'h52, 1, 0, 8'h75});
        tbl.push_back('{8'hE0, 0, 1, 8'h52, 0, 0, 8'hE0});
        tbl.push_back('{8'hF0, 0, 1, 8'h52, 0, 0, 8'hF0});
        tbl.push_back('{8'h75, 0, 1, 8'h00, 1, 0, 8'h75});
        tbl.push_back('{8'h75, 0, 1, 8'h00, 0, 0, 8'h75});
        tbl.push_back('{8'h1D, 0, 1, 8'h1A, 1, 0, 8'h1D});
        tbl.push_back('{8'h1D, 0, 1, 8'h1A, 0, 0, 8'h1D});
        tbl.push_back('{8'h1D, 0, 1, 8'h1A, 0, 0, 8'h1D});
        tbl.push_back('{8'hF0, 0, 1, 8'h1A, 0, 0, 8'hF0});
        tbl.push_back('{8'h1D, 0, 1, 8'h00, 1, 0, 8'h1D});
`ifdef PS2_PARITY_CHECK_EN
        tbl.push_back('{8'h1C, 1, 1, 8'h00, 0, 1, 8'h1D});
        tbl.push_back('{8'h29, 0, 0, 8'h00, 0, 1, 8'h1D});
`else
        tbl.push_back('{8'h1C, 1, 1, 8'h04, 1, 0, 8'h1C});
        tbl.push_back('{8'h29, 0, 0, 8'h04, 0, 1, 8'h1C});
`endif

        do_reset();
        chk("reset_keycode",    32'(bus.keycode),    32'h00);
        chk("reset_scan_byte",  32'(bus.scan_byte),  32'h00);
        chk("reset_key_event",  32'(bus.key_event),  32'h0);
        chk("reset_scan_valid", 32'(bus.scan_valid), 32'h0);
        chk("reset_frame_err",  32'(bus.frame_err),  32'h0);
        rst = 1'b0;
        idle_wait(4);

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            ev0 = ev_cnt; err0 = err_cnt;
            send_frame(tbl[i].code, tbl[i].flip, tbl[i].stop);
            chk($sformatf("tbl%0d_keycode", i),   32'(bus.keycode),   32'(tbl[i].exp_key));
            chk($sformatf("tbl%0d_events", i),    32'(ev_cnt - ev0),  32'(tbl[i].exp_ev));
            chk($sformatf("tbl%0d_frame_err", i), 32'(err_cnt - err0), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_scan_byte", i), 32'(bus.scan_byte), 32'(tbl[i].exp_sb));
        end

        // Randomized frames against the model
        do_reset();
        rst = 1'b0;
        idle_wait(4);
        m_ext = 1'b0; m_brk = 1'b0; m_key = 8'h00; sb_exp = 8'h00;
        for (int i = 0; i < 60; i++) begin
            b = pool[$urandom_range(0, 12)];
            stop = ($urandom_range(0, 7) != 0);
            prev_key = int'(m_key);
            if (stop) begin
                model_byte(b);
                sb_exp = b;
            end
            ev0 = ev_cnt; err0 = err_cnt;
            send_frame(b, 1'b0, stop);
            chk($sformatf("rnd%0d_keycode", i),   32'(bus.keycode),    32'(m_key));
            chk($sformatf("rnd%0d_events", i),    32'(ev_cnt - ev0),   32'(int'(m_key) != prev_key));
            chk($sformatf("rnd%0d_frame_err", i), 32'(err_cnt - err0), 32'(!stop));
            chk($sformatf("rnd%0d_scan_byte", i), 32'(bus.scan_byte),  32'(sb_exp));
        end

        // Long gap just inside the timeout must not abort the frame
        do_reset();
        rst = 1'b0;
        idle_wait(4);
        err0 = err_cnt;
        send_bits(make_frame(8'h1B, 1'b0, 1'b1), 5);
        repeat (TO - 40) @(posedge clk);
        #1;
        send_bits(make_frame(8'h1B, 1'b0, 1'b1) >> 5, 6);
        idle_wait(12);
        chk("gap_keycode",   32'(bus.keycode),    32'h16);
        chk("gap_frame_err", 32'(err_cnt - err0), 32'h0);

        // Timeout after 4 data bits, then a good frame
        do_reset();
        rst = 1'b0;
        idle_wait(4);
        ev0 = ev_cnt; err0 = err_cnt; sv0 = sv_cnt;
        send_bits(make_frame(8'h23, 1'b0, 1'b1), 5);
        idle_wait(TO + 20);
        chk("timeout_frame_err",  32'(err_cnt - err0), 32'h1);
        chk("timeout_scan_valid", 32'(sv_cnt - sv0),   32'h0);
        chk("timeout_keycode",    32'(bus.keycode),    32'h00);
        send_frame(8'h23, 1'b0, 1'b1);
        chk("after_timeout_keycode",   32'(bus.keycode),    32'h07);
        chk("after_timeout_frame_err", 32'(err_cnt - err0), 32'h1);
        chk("after_timeout_events",    32'(ev_cnt - ev0),   32'h1);

        // Reset mid-frame discards the partial frame
        send_frame(8'h1D, 1'b0, 1'b1);
        chk("pre_reset_keycode", 32'(bus.keycode), 32'h1A);
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 5);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_keycode",   32'(bus.keycode),   32'h00);
        chk("midreset_scan_byte", 32'(bus.scan_byte), 32'h00);
        chk("midreset_key_event", 32'(bus.key_event), 32'h0);
        rst = 1'b0;
        idle_wait(4);
        err0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("post_reset_keycode",   32'(bus.keycode),    32'h04);
        chk("post_reset_scan_byte", 32'(bus.scan_byte),  32'h1C);
        chk("post_reset_frame_err", 32'(err_cnt - err0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
